// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory read feeding a 2-entry decode FIFO.
// Define FETCH_TIMEOUT_EN to add a 15-cycle read timeout with a sticky fetch_err flag.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    output logic              pc_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    input  logic              flush,
    output logic              fetch_err
);

    typedef enum logic [1:0] {StIdle, StBusy, StDiscard} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] fifo_pc_q    [2];
    logic [DATA_W-1:0] fifo_instr_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        fifo_count_q;
    logic              accept, push, pop, timeout;

    assign accept = pc_valid && pc_ready;
    // Flush wins over both FIFO operations; an ack coinciding with flush is dropped.
    assign push   = (state_q == StBusy) && mem_ack && !flush;
    assign pop    = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StBusy;
            end
            StBusy: begin
                if (mem_ack || timeout) state_d = StIdle;
                else if (flush)         state_d = StDiscard;
            end
            StDiscard: begin
                if (mem_ack || timeout) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pc_ready  = (state_q == StIdle) && (fifo_count_q < 2'd2) && !flush;
        mem_req   = (state_q != StIdle);
        out_valid = (fifo_count_q != 2'd0);
        out_pc    = fifo_pc_q[rd_ptr_q];
        out_instr = fifo_instr_q[rd_ptr_q];
    end

    // Address only loads on acceptance, so it is stable for the whole request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q <= '0;
        end else if (accept) begin
            mem_addr_q <= pc;
        end
    end

    assign mem_addr = mem_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_count_q <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else if (flush) begin
            fifo_count_q <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
        end else begin
            if (push) begin
                fifo_pc_q[wr_ptr_q]    <= mem_addr_q;
                fifo_instr_q[wr_ptr_q] <= mem_rdata;
                wr_ptr_q               <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push && !pop) begin
                fifo_count_q <= fifo_count_q + 2'd1;
            end else if (pop && !push) begin
                fifo_count_q <= fifo_count_q - 2'd1;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] tmo_cnt_q;
    logic       fetch_err_q;
    logic       tmo_restart;

    // The window restarts on entry to BUSY and again on the BUSY->DISCARD redirect.
    assign tmo_restart = (state_q == StIdle) || ((state_q == StBusy) && (state_d == StDiscard));
    assign timeout     = (state_q != StIdle) && (tmo_cnt_q == 4'd15) && !mem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q   <= 4'd0;
            fetch_err_q <= 1'b0;
        end else begin
            if (tmo_restart) begin
                tmo_cnt_q <= 4'd0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 4'd1;
            end
            if (timeout) begin
                fetch_err_q <= 1'b1;
            end
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: queue-based reference model plus pop monitor.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } entry_t;

    logic       clk;
    logic       rst;
    logic [7:0] pc;
    logic       pc_valid;
    logic       pc_ready;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pc;
    logic [7:0] out_instr;
    logic       flush;
    logic       fetch_err;

    instr_fetch_unit #(
        .ADDR_W(8),
        .DATA_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc),
        .pc_valid (pc_valid),
        .pc_ready (pc_ready),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc   (out_pc),
        .out_instr(out_instr),
        .flush    (flush),
        .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: accepted-and-delivered entries, plus the single in-flight read.
    entry_t     exp_q[$];
    entry_t     pend;
    logic [7:0] mem_model [256];
    bit         outstanding   = 0;
    bit         discard       = 0;
    bit         exp_err       = 0;
    bit         just_accepted = 0;
    int         busy_cycles   = 0;

    bit mem_auto  = 0;
    int delay_max = 0;
    bit armed     = 0;
    int wait_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        outstanding = 0;
        discard     = 0;
        exp_err     = 0;
        busy_cycles = 0;
        armed       = 0;
    endtask

    // Runs at the falling edge: compare the current cycle, then apply the upcoming edge.
    task automatic eval();
        bit exp_ready, ack_now, tmo;
        just_accepted = 0;
        exp_ready = !outstanding && (exp_q.size() < 2) && !flush;
        check("pc_ready", 32'(pc_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("mem_req", 32'(mem_req), 32'(outstanding));
        if (outstanding) check("mem_addr", 32'(mem_addr), 32'(pend.addr));
        check("fetch_err", 32'(fetch_err), 32'(exp_err));
        if (!rst) begin
            ack_now = mem_ack && outstanding;
            tmo = 0;
            if (outstanding) begin
                busy_cycles++;
`ifdef FETCH_TIMEOUT_EN
                if (busy_cycles == 16 && !mem_ack) tmo = 1;
`endif
            end
            if (flush) exp_q.delete();
            if (outstanding) begin
                if (ack_now) begin
                    if (!discard && !flush) exp_q.push_back(pend);
                    outstanding = 0;
                end else if (tmo) begin
                    outstanding = 0;
                    exp_err     = 1;
                end else if (flush && !discard) begin
                    discard     = 1;
                    busy_cycles = 0;
                end
            end else if (pc_valid && exp_ready) begin
                pend          = '{addr: pc, data: mem_model[pc]};
                outstanding   = 1;
                discard       = 0;
                busy_cycles   = 0;
                just_accepted = 1;
            end
        end
    endtask

    task automatic mem_drive();
        if (mem_auto) begin
            mem_ack = 1'b0;
            if (mem_req && !rst) begin
                if (!armed) begin
                    armed    = 1;
                    wait_cnt = $urandom_range(0, delay_max);
                end
                if (wait_cnt == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_model[mem_addr];
                    armed     = 0;
                end else begin
                    wait_cnt--;
                end
            end else begin
                armed = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        eval();
        @(posedge clk);
        #1;
        mem_drive();
    endtask

    task automatic fetch(input logic [7:0] a);
        int n;
        pc       = a;
        pc_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!just_accepted && n < 20);
        pc_valid = 1'b0;
        check("fetch_accept_mem_req", 32'(mem_req), 32'd1);
        n = 0;
        while (outstanding && n < 20) begin
            step();
            n++;
        end
        check("fetch_done_mem_req", 32'(mem_req), 32'd0);
    endtask

    // Monitor: the head of the DUT FIFO must match the model head; pop on handshake.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && !flush && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q[0];
                    check("out_pc", 32'(out_pc), 32'(e.addr));
                    check("out_instr", 32'(out_instr), 32'(e.data));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = 8'($urandom);
        mem_model[8'h10] = 8'hA5;
        mem_model[8'h20] = 8'h77;
        rst = 1'b1; pc = 8'h00; pc_valid = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
        out_ready = 1'b1; flush = 1'b0;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", 32'(out_pc), 32'd0);
        check("rst_out_instr", 32'(out_instr), 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        step();
        step();
        rst = 1'b0;
        mem_auto = 1; delay_max = 0;
        step();

        // Zero-wait fetch of 0x10: out_valid two cycles after acceptance.
        pc = 8'h10; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        check("t1_mem_req_n1", 32'(mem_req), 32'd1);
        check("t1_out_valid_n1", 32'(out_valid), 32'd0);
        step();
        check("t1_out_valid_n2", 32'(out_valid), 32'd1);
        check("t1_out_pc", 32'(out_pc), 32'h10);
        check("t1_out_instr", 32'(out_instr), 32'hA5);
        step();
        step();

        // Back-pressure: two entries fill the FIFO and pc_ready drops.
        out_ready = 1'b0;
        fetch(8'h01);
        fetch(8'h02);
        check("t2_pc_ready_full", 32'(pc_ready), 32'd0);
        check("t2_head_pc", 32'(out_pc), 32'h01);
        pc = 8'h03; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        check("t2_no_accept_when_full", 32'(mem_req), 32'd0);
        out_ready = 1'b1;
        step();
        check("t2_second_pc", 32'(out_pc), 32'h02);
        check("t2_second_instr", 32'(out_instr), 32'(mem_model[8'h02]));
        step();
        check("t2_drained", 32'(out_valid), 32'd0);

        // Flush while BUSY: FIFO empties, DISCARD drops the late 0x77.
        out_ready = 1'b0;
        fetch(8'h05);
        mem_auto = 0; mem_ack = 1'b0;
        pc = 8'h20; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        flush = 1'b1;
        step();
        check("t3_out_valid_flushed", 32'(out_valid), 32'd0);
        check("t3_mem_req_discard", 32'(mem_req), 32'd1);
        flush = 1'b0;
        #1;
        check("t3_pc_ready_discard", 32'(pc_ready), 32'd0);
        mem_ack = 1'b1; mem_rdata = 8'h77;
        step();
        mem_ack = 1'b0;
        check("t3_dropped_out_valid", 32'(out_valid), 32'd0);
        check("t3_idle_mem_req", 32'(mem_req), 32'd0);
        check("t3_idle_pc_ready", 32'(pc_ready), 32'd1);
        step();
        check("t3_still_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

        // Simultaneous push and pop with one entry held.
        mem_auto = 1; delay_max = 0;
        out_ready = 1'b0;
        fetch(8'h30);
        pc = 8'h31; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("t4_out_valid", 32'(out_valid), 32'd1);
        check("t4_head_pc", 32'(out_pc), 32'h31);
        check("t4_head_instr", 32'(out_instr), 32'(mem_model[8'h31]));
        check("t4_count_one", 32'(pc_ready), 32'd1);
        step();
        step();

        // Reset pulse mid-read, then a stray ack.
        mem_auto = 0; mem_ack = 1'b0;
        pc = 8'h40; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        check("t5_busy", 32'(mem_req), 32'd1);
        rst = 1'b1;
        model_reset();
        #1;
        check("t5_rst_mem_req", 32'(mem_req), 32'd0);
        check("t5_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_out_pc", 32'(out_pc), 32'd0);
        check("t5_rst_out_instr", 32'(out_instr), 32'd0);
        check("t5_rst_fetch_err", 32'(fetch_err), 32'd0);
        check("t5_rst_pc_ready", 32'(pc_ready), 32'd1);
        step();
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'h99;
        step();
        mem_ack = 1'b0;
        check("t5_stray_out_valid", 32'(out_valid), 32'd0);
        check("t5_stray_mem_req", 32'(mem_req), 32'd0);
        step();
        check("t5_stray_out_valid_late", 32'(out_valid), 32'd0);

`ifdef FETCH_TIMEOUT_EN
        // No ack: read times out, fetch_err latches.
        pc = 8'h50; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        for (int n = 0; n < 20 && mem_req; n++) step();
        check("t6_mem_req_fell", 32'(mem_req), 32'd0);
        check("t6_fetch_err", 32'(fetch_err), 32'd1);
        check("t6_pc_ready", 32'(pc_ready), 32'd1);
        step();
        step();
        check("t6_fetch_err_sticky", 32'(fetch_err), 32'd1);
`endif

        // Randomized traffic against the model.
        mem_auto = 1; delay_max = 3; mem_ack = 1'b0;
        for (int i = 0; i < 500; i++) begin
            pc        = 8'($urandom);
            pc_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            step();
        end
        pc_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("final_out_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, giving the width of the program-counter value and memory address.
REQ-002 The module SHALL have parameter DATA_W, default 8, giving the width of the instruction word.
REQ-003 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state SHALL update on its rising edge.
REQ-004 The port rst SHALL be an input, 1 bit wide, and be the asynchronous, active-high reset.
REQ-005 The ports pc, pc_valid and pc_ready SHALL carry the upstream program-counter handshake: pc is input [ADDR_W-1:0], pc_valid is an input, pc_ready is an output.
REQ-006 The ports mem_req, mem_addr, mem_ack and mem_rdata SHALL form the memory read port: mem_req is an output, mem_addr is output [ADDR_W-1:0], mem_ack is an input one-cycle pulse, mem_rdata is input [DATA_W-1:0] and is valid with mem_ack.
REQ-007 The ports out_valid, out_ready, out_pc and out_instr SHALL form the downstream decode handshake: out_valid is an output, out_ready is an input, out_pc is output [ADDR_W-1:0], out_instr is output [DATA_W-1:0].
REQ-008 The port flush SHALL be an input, 1 bit wide, and be a branch/redirect discard request.
REQ-009 The port fetch_err SHALL be an output, 1 bit wide, and be a sticky timeout error flag.

Function
REQ-010 The block SHALL implement an FSM with three states: IDLE, BUSY and DISCARD.
REQ-011 pc_ready SHALL equal (state==IDLE) && (fifo_count<2) && !flush.
REQ-012 A PC SHALL be accepted on pc_valid&&pc_ready; at that edge pc is latched into mem_addr and the FSM moves IDLE->BUSY.
REQ-013 mem_req SHALL be 1 exactly in BUSY and DISCARD, and mem_addr SHALL stay stable while mem_req is 1.
REQ-014 In BUSY, mem_ack SHALL push {mem_addr, mem_rdata} into the FIFO and move the FSM to IDLE on the same edge.
REQ-015 In DISCARD, mem_ack SHALL drop mem_rdata without pushing it and move the FSM to IDLE.
REQ-016 At most one memory read SHALL be outstanding; mem_ack while in IDLE SHALL be ignored.
REQ-017 The output FIFO SHALL be 2 entries deep; out_valid SHALL equal (fifo_count!=0), and out_pc/out_instr SHALL present the oldest entry.
REQ-018 A pop SHALL occur on out_valid&&out_ready; a simultaneous push and pop SHALL leave fifo_count unchanged and preserve order.
REQ-019 Flush SHALL clear the FIFO (fifo_count=0) on that edge, take priority over push and pop, and move BUSY->DISCARD; in IDLE or DISCARD the state SHALL be unchanged.
REQ-020 Latency: a PC accepted at edge N SHALL raise mem_req in cycle N+1, and mem_ack at edge M SHALL raise out_valid in cycle M+1; a zero-wait memory gives PC-to-out_valid of 2 cycles.
REQ-021 Output data SHALL not change while out_valid&&!out_ready, except on flush.

Reset
REQ-022 While rst is 1, the state SHALL be IDLE, fifo_count 0, FIFO pointers 0, mem_req 0, mem_addr 0, out_valid 0, out_pc 0, out_instr 0, fetch_err 0, and the timeout counter 0.
REQ-023 A reset asserted mid-transaction SHALL abandon it; an ack arriving after reset release SHALL be ignored per REQ-016.

Configuration
REQ-024 When macro FETCH_TIMEOUT_EN is defined, a 4-bit counter SHALL count cycles in BUSY/DISCARD (cleared on entry); when it reaches 15 without mem_ack, the FSM SHALL return to IDLE with no push, and fetch_err SHALL be set and held until rst.
REQ-025 When FETCH_TIMEOUT_EN is undefined, no counter SHALL exist, fetch_err SHALL be tied to 0, and BUSY/DISCARD SHALL wait for mem_ack indefinitely.

Verification
REQ-026 The bench SHALL check: pc=0x10 accepted, mem_rdata=0xA5 acked the next cycle -> out_valid 2 cycles after acceptance with out_pc=0x10 and out_instr=0xA5.
REQ-027 The bench SHALL check: out_ready=0 while fetching pc 0x01 and 0x02 -> pc_ready=0 with fifo_count=2, then pops return 0x01 then 0x02 in order.
REQ-028 The bench SHALL check: flush in BUSY for pc=0x20 while the FIFO holds one entry -> out_valid=0 next cycle, FSM in DISCARD, the later ack with 0x77 does not appear at the output.
REQ-029 The bench SHALL check: with fifo_count=1, a push and a pop on the same edge -> fifo_count stays 1 and the new entry is at the head.
REQ-030 The bench SHALL check: rst pulsed in BUSY -> all outputs return to reset values, and a stray mem_ack afterwards produces no out_valid.
REQ-031 The bench SHALL check, with FETCH_TIMEOUT_EN defined: no mem_ack for 15 cycles -> mem_req falls, fetch_err=1 and stays 1, and pc_ready returns to 1.
